pacman_mover: RTL and testbench



---
 rtl/pacman_mover_pkg.sv | 76 +++++++
 rtl/pacman_mover_if.sv | 31 +++
 rtl/pacman_mover_maze_tile_rom.sv | 22 ++
 rtl/pacman_mover.sv | 145 ++++++++++++++
 tb/tb_pacman_mover.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pacman_mover_pkg.sv
// Shared types, constants and helpers for the Pac-Man motion controller.
package pacman_mover_pkg;

  localparam int TILE       = 16;
  localparam int COLS       = 40;
  localparam int ROWS       = 22;
  localparam int MAZE_DEPTH = COLS * ROWS;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_PEND,
    ST_RD_CUR,
    ST_MOVE
  } state_t;

  // Tile lookup result: forced marks an off-maze row (always a wall, no ROM read).
  typedef struct packed {
    logic       forced;
    logic [9:0] addr;
  } tile_ref_t;

  function automatic dir_t opposite(dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_NONE;
    endcase
  endfunction

  function automatic dir_t decode_key(logic [7:0] k);
    case (k)
      KEY_W:   return DIR_UP;
      KEY_A:   return DIR_LEFT;
      KEY_S:   return DIR_DOWN;
      KEY_D:   return DIR_RIGHT;
      default: return DIR_NONE;
    endcase
  endfunction

  // Tile adjacent to an aligned sprite at (x,y) in direction d; columns wrap through the tunnel.
  function automatic tile_ref_t tile_ahead(logic [9:0] x, logic [9:0] y, dir_t d);
    int        c;
    int        r;
    tile_ref_t t;
    c = int'(x) / TILE;
    r = int'(y) / TILE;
    case (d)
      DIR_UP:    r = r - 1;
      DIR_DOWN:  r = r + 1;
      DIR_LEFT:  c = c - 1;
      DIR_RIGHT: c = c + 1;
      default:   ;
    endcase
    if (c < 0) c = COLS - 1;
    else if (c >= COLS) c = 0;
    t.forced = (r < 0) || (r >= ROWS);
    t.addr   = t.forced ? 10'd0 : 10'(r * COLS + c);
    return t;
  endfunction

endpackage

// File: rtl/pacman_mover_if.sv
// Bus between the mover and its environment: controls, maze load port, sprite outputs.
// No valid/ready handshake: every input is sampled on each Clk (frame_clk is edge-detected
// internally, keycode is a level), maze_we writes one tile per Clk it is high, and all
// outputs are registered except is_ball, which is combinational from DrawX/DrawY.
interface pacman_mover_if;
  import pacman_mover_pkg::*;

  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       maze_we;
  logic [9:0] maze_addr;
  logic       maze_data;
  logic       is_ball;
  logic [9:0] pac_x;
  logic [9:0] pac_y;
  dir_t       dir;
  logic       moving;
  state_t     state;

  modport master (
    output frame_clk, keycode, DrawX, DrawY, maze_we, maze_addr, maze_data,
    input  is_ball, pac_x, pac_y, dir, moving, state
  );

  modport slave (
    input  frame_clk, keycode, DrawX, DrawY, maze_we, maze_addr, maze_data,
    output is_ball, pac_x, pac_y, dir, moving, state
  );
endinterface

// File: rtl/pacman_mover_maze_tile_rom.sv
// 880x1 wall bitmap (1 = wall), 40 columns x 22 rows, one-cycle registered read.
// Contents are loaded through the write port by the maze loader and shared with the wall renderer.
module maze_tile_rom
  import pacman_mover_pkg::*;
(
  input  logic       Clk,
  input  logic [9:0] addr,
  output logic       wall,
  input  logic       we,
  input  logic [9:0] waddr,
  input  logic       wdata
);

  logic bitmap [MAZE_DEPTH];

  // Load port write and registered read; out-of-range addresses read as wall.
  always_ff @(posedge Clk) begin
    if (we && (waddr < 10'(MAZE_DEPTH))) bitmap[waddr] <= wdata;
    wall <= (addr < 10'(MAZE_DEPTH)) ? bitmap[addr] : 1'b1;
  end

endmodule

// File: rtl/pacman_mover.sv
// Per-frame Pac-Man motion controller: queued turns, wall checks, tunnel wrap, sprite hit flag.
module pacman_mover
  import pacman_mover_pkg::*;
#(
  parameter int STEP    = 1,
  parameter int START_X = 304,
  parameter int START_Y = 256
) (
  input logic           Clk,
  input logic           Reset,
  pacman_mover_if.slave bus
);

  localparam logic [9:0] STEP10 = 10'(STEP);
  localparam logic [9:0] X_WRAP = 10'(TILE * (COLS - 1));

  logic      frame_s1, frame_s2, frame_prev;
  logic      frame_rise;
  dir_t      pending, key_dir, dir;
  state_t    state;
  logic [9:0] pac_x, pac_y;
  logic      moving;
  logic      forced_q;
  logic      aligned, take_pend;
  tile_ref_t ahead_pend, ahead_dir;
  logic [9:0] rom_addr;
  logic      rom_wall;
  logic      wall;

  assign frame_rise = frame_s2 & ~frame_prev;
  assign key_dir    = decode_key(bus.keycode);
  assign aligned    = ((pac_x % 10'(TILE)) == 10'd0) && ((pac_y % 10'(TILE)) == 10'd0);
  assign take_pend  = (pending != DIR_NONE) && (pending != dir);
  assign ahead_pend = tile_ahead(pac_x, pac_y, pending);
  assign ahead_dir  = tile_ahead(pac_x, pac_y, dir);
  // In RD_PEND the next lookup is always the current direction.
  assign rom_addr   = (state == ST_IDLE && take_pend) ? ahead_pend.addr : ahead_dir.addr;
  assign wall       = forced_q | rom_wall;

  maze_tile_rom u_rom (
    .Clk   (Clk),
    .addr  (rom_addr),
    .wall  (rom_wall),
    .we    (bus.maze_we),
    .waddr (bus.maze_addr),
    .wdata (bus.maze_data)
  );

  // Two-flop synchroniser plus edge register for the asynchronous frame strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_s1   <= 1'b0;
      frame_s2   <= 1'b0;
      frame_prev <= 1'b0;
    end else begin
      frame_s1   <= bus.frame_clk;
      frame_s2   <= frame_s1;
      frame_prev <= frame_s2;
    end
  end

  // Queued turn: any WASD key overwrites it, everything else holds it.
  always_ff @(posedge Clk) begin
    if (Reset) pending <= DIR_NONE;
    else if (key_dir != DIR_NONE) pending <= key_dir;
  end

  // Frame evaluation FSM: decide the direction, consult the maze, then step once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      dir      <= DIR_NONE;
      pac_x    <= 10'(START_X);
      pac_y    <= 10'(START_Y);
      moving   <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_rise) begin
            // A reversal never needs a wall check; NONE has no opposite worth taking.
            if (pending != DIR_NONE && pending == opposite(dir)) begin
              dir   <= pending;
              state <= ST_MOVE;
            end else if (!aligned) begin
              state <= ST_MOVE;
            end else if (take_pend) begin
              forced_q <= ahead_pend.forced;
              state    <= ST_RD_PEND;
            end else if (dir != DIR_NONE) begin
              forced_q <= ahead_dir.forced;
              state    <= ST_RD_CUR;
            end else begin
              moving <= 1'b0;
            end
          end
        end
        ST_RD_PEND: begin
          if (!wall) begin
            dir   <= pending;
            state <= ST_MOVE;
          end else if (dir == DIR_NONE) begin
            moving <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            forced_q <= ahead_dir.forced;
            state    <= ST_RD_CUR;
          end
        end
        ST_RD_CUR: begin
          if (wall) begin
            moving <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            state <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          case (dir)
            DIR_UP:    pac_y <= pac_y - STEP10;
            DIR_DOWN:  pac_y <= pac_y + STEP10;
            DIR_LEFT:  pac_x <= (pac_x == 10'd0) ? X_WRAP : pac_x - STEP10;
            DIR_RIGHT: pac_x <= (pac_x == X_WRAP) ? 10'd0 : pac_x + STEP10;
            default:   ;
          endcase
          moving <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pac_x  = pac_x;
  assign bus.pac_y  = pac_y;
  assign bus.dir    = dir;
  assign bus.moving = moving;
  assign bus.state  = state;
  // 11-bit compares so pac_x + TILE cannot overflow at the right edge.
  assign bus.is_ball = ({1'b0, bus.DrawX} >= {1'b0, pac_x}) &&
                       ({1'b0, bus.DrawX} <  ({1'b0, pac_x} + 11'(TILE))) &&
                       ({1'b0, bus.DrawY} >= {1'b0, pac_y}) &&
                       ({1'b0, bus.DrawY} <  ({1'b0, pac_y} + 11'(TILE)));

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover with a frame-level behavioural model and literal pins.
module tb_pacman_mover;
  import pacman_mover_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pacman_mover_if bus ();

  pacman_mover dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int passed = 0;
  int total  = 0;
  logic [23:0] exp_q[$];

  // Frame-level model: position, direction, queued turn, maze copy.
  int   m_x, m_y;
  dir_t m_dir, m_pend;
  bit   m_mov;
  bit   maze_m [880];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic dir_t m_rev(dir_t d);
    if (d == DIR_UP) return DIR_DOWN;
    if (d == DIR_DOWN) return DIR_UP;
    if (d == DIR_LEFT) return DIR_RIGHT;
    if (d == DIR_RIGHT) return DIR_LEFT;
    return DIR_NONE;
  endfunction

  function automatic bit open_ahead(dir_t d);
    int c = m_x / 16;
    int r = m_y / 16;
    if (d == DIR_UP) r--;
    if (d == DIR_DOWN) r++;
    if (d == DIR_LEFT) c--;
    if (d == DIR_RIGHT) c++;
    c = (c + 40) % 40;
    if (r < 0 || r > 21) return 1'b0;
    return !maze_m[r * 40 + c];
  endfunction

  task automatic m_step();
    m_mov = 1'b1;
    if (m_dir == DIR_UP) m_y = m_y - 1;
    if (m_dir == DIR_DOWN) m_y = m_y + 1;
    // Horizontal range is 0..624 inclusive and wraps end to end.
    if (m_dir == DIR_LEFT) m_x = (m_x + 624) % 625;
    if (m_dir == DIR_RIGHT) m_x = (m_x + 1) % 625;
  endtask

  task automatic model_frame();
    bit al = (m_x % 16 == 0) && (m_y % 16 == 0);
    if (m_pend != DIR_NONE && m_pend == m_rev(m_dir)) begin
      m_dir = m_pend;
      m_step();
    end else if (!al) begin
      m_step();
    end else if (m_pend != DIR_NONE && m_pend != m_dir && open_ahead(m_pend)) begin
      m_dir = m_pend;
      m_step();
    end else if (m_dir != DIR_NONE && open_ahead(m_dir)) begin
      m_step();
    end else begin
      m_mov = 1'b0;
    end
    exp_q.push_back({3'(m_dir), m_mov, 10'(m_x), 10'(m_y)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic ball_at(string name, int x, int y, logic exp);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    #1;
    check(name, 32'(bus.is_ball), 32'(exp));
  endtask

  task automatic compare_outputs();
    logic [23:0] e;
    int ex, ey;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL exp_q: got empty queue expected an entry");
      return;
    end
    e  = exp_q.pop_front();
    ex = int'(e[19:10]);
    ey = int'(e[9:0]);
    check("frame_x", 32'(bus.pac_x), 32'(ex));
    check("frame_y", 32'(bus.pac_y), 32'(ey));
    check("frame_dir", 32'(bus.dir), 32'(e[23:21]));
    check("frame_moving", 32'(bus.moving), 32'(e[20]));
    ball_at("ball_in", ex + 15, ey + 15, 1'b1);
    ball_at("ball_right", ex + 16, ey, 1'b0);
    ball_at("ball_below", ex, ey + 16, 1'b0);
  endtask

  // One frame strobe; outputs are compared 4 Clk after the internal rise.
  task automatic frame();
    bus.frame_clk = 1'b1;
    model_frame();
    repeat (6) @(negedge clk);
    compare_outputs();
    bus.frame_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press(logic [7:0] k);
    bus.keycode = k;
    @(negedge clk);
    bus.keycode = 8'h00;
    if (k == 8'h1A) m_pend = DIR_UP;
    if (k == 8'h04) m_pend = DIR_LEFT;
    if (k == 8'h16) m_pend = DIR_DOWN;
    if (k == 8'h07) m_pend = DIR_RIGHT;
  endtask

  task automatic set_tile(int c, int r, bit v);
    bus.maze_we   = 1'b1;
    bus.maze_addr = 10'(r * 40 + c);
    bus.maze_data = v;
    @(negedge clk);
    bus.maze_we   = 1'b0;
    maze_m[r * 40 + c] = v;
  endtask

  task automatic clear_maze();
    for (int i = 0; i < 880; i++) begin
      bus.maze_we   = 1'b1;
      bus.maze_addr = 10'(i);
      bus.maze_data = 1'b0;
      maze_m[i]     = 1'b0;
      @(negedge clk);
    end
    bus.maze_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.frame_clk = 1'b0;
    bus.keycode   = 8'h00;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    m_x    = 304;
    m_y    = 256;
    m_dir  = DIR_NONE;
    m_pend = DIR_NONE;
    m_mov  = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    rst = 1'b1;
    bus.frame_clk = 1'b0;
    bus.keycode   = 8'h00;
    bus.DrawX     = 10'd0;
    bus.DrawY     = 10'd0;
    bus.maze_we   = 1'b0;
    bus.maze_addr = 10'd0;
    bus.maze_data = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values and sprite footprint.
    do_reset();
    check("rst_x", 32'(bus.pac_x), 32'd304);
    check("rst_y", 32'(bus.pac_y), 32'd256);
    check("rst_dir", 32'(bus.dir), 32'(DIR_NONE));
    check("rst_moving", 32'(bus.moving), 32'd0);
    ball_at("rst_ball_tl", 304, 256, 1'b1);
    ball_at("rst_ball_br", 319, 271, 1'b1);
    ball_at("rst_ball_out", 320, 256, 1'b0);

    // Open maze, run right one tile; a non-WASD key must not disturb the queued turn.
    clear_maze();
    press(KEY_D);
    repeat (8) frame();
    press(8'h2C);
    repeat (8) frame();
    check("run_x", 32'(bus.pac_x), 32'd320);
    check("run_dir", 32'(bus.dir), 32'(DIR_RIGHT));
    check("run_moving", 32'(bus.moving), 32'd1);
    // Wall two tiles ahead: sprite stops at x=336 and keeps its direction.
    set_tile(22, 16, 1'b1);
    repeat (17) frame();
    check("stop_x", 32'(bus.pac_x), 32'd336);
    check("stop_moving", 32'(bus.moving), 32'd0);
    check("stop_dir", 32'(bus.dir), 32'(DIR_RIGHT));

    // Wall directly ahead of the start tile: the turn is refused.
    do_reset();
    clear_maze();
    set_tile(20, 16, 1'b1);
    press(KEY_D);
    frame();
    check("wall_x", 32'(bus.pac_x), 32'd304);
    check("wall_moving", 32'(bus.moving), 32'd0);
    check("wall_dir", 32'(bus.dir), 32'(DIR_NONE));

    // Queued turn waits for tile alignment.
    do_reset();
    clear_maze();
    press(KEY_D);
    repeat (6) frame();
    check("q_x310", 32'(bus.pac_x), 32'd310);
    press(KEY_W);
    repeat (10) frame();
    check("q_x320", 32'(bus.pac_x), 32'd320);
    check("q_dir_still_right", 32'(bus.dir), 32'(DIR_RIGHT));
    frame();
    check("q_dir_up", 32'(bus.dir), 32'(DIR_UP));
    check("q_y255", 32'(bus.pac_y), 32'd255);
    check("q_x_hold", 32'(bus.pac_x), 32'd320);

    // Reversal mid-tile is immediate.
    do_reset();
    press(KEY_D);
    repeat (6) frame();
    press(KEY_A);
    frame();
    check("rev_dir", 32'(bus.dir), 32'(DIR_LEFT));
    check("rev_x", 32'(bus.pac_x), 32'd309);

    // Up to row 10, then left through the tunnel.
    do_reset();
    press(KEY_W);
    repeat (96) frame();
    check("tun_y160", 32'(bus.pac_y), 32'd160);
    press(KEY_A);
    repeat (304) frame();
    check("tun_x0", 32'(bus.pac_x), 32'd0);
    check("tun_dir", 32'(bus.dir), 32'(DIR_LEFT));
    frame();
    check("tun_x624", 32'(bus.pac_x), 32'd624);
    ball_at("tun_ball_edge", 639, 165, 1'b1);
    ball_at("tun_ball_left", 623, 165, 1'b0);

    // Reset while the position write is pending.
    do_reset();
    press(KEY_D);
    repeat (6) frame();
    bus.frame_clk = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.state == ST_MOVE) seen = 1'b1;
    end
    check("abort_reached_move", 32'(seen), 32'd1);
    rst = 1'b1;
    bus.frame_clk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_x", 32'(bus.pac_x), 32'd304);
    check("abort_y", 32'(bus.pac_y), 32'd256);
    check("abort_state", 32'(bus.state), 32'(ST_IDLE));
    check("abort_moving", 32'(bus.moving), 32'd0);

    // ---------------- report ----------------
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
